reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter W, default 8: register data width in bits.
REQ-002 Parameter D, default 3: address width; register count N = 2**D.
REQ-003 Parameter NR, default 2: number of independent read ports.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding enabled.
REQ-005 Parameter R0_ZERO, default 0: 1 = register 0 hardwired to zero.
REQ-006 CLK  input  1  sole clock; all state updates on rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset; this block has one clock and reset is synchronous and active-high.
REQ-008 WriteReg  input  1  write enable.
REQ-009 WReg  input  D  write address.
REQ-010 WriteValue  input  W  write data.
REQ-011 ClearReq  input  1  request a sequential clear of all registers; sampled only in IDLE.
REQ-012 ReadAddr  input  NR*D  packed read addresses; port i occupies bits [i*D +: D].
REQ-013 ReadData  output  NR*W  packed combinational read data; port i occupies bits [i*W +: W].
REQ-014 Busy  output  1  high while a clear is in progress.
REQ-015 ClearDone  output  1  one-cycle pulse when a clear completes.
REQ-016 Written  output  N  per-register flag; bit k = register k written since the last clear.

Function
REQ-017 The block SHALL have two states: IDLE and CLEAR; Busy SHALL be 1 exactly when the state is CLEAR.
REQ-018 In IDLE with ClearReq=1 sampled at edge t, the block SHALL enter CLEAR with clear index 0, and that edge SHALL perform no user write.
REQ-019 In CLEAR, each edge SHALL write 0 to register[index], clear Written[index] and increment index; the write at index N-1 SHALL return the state to IDLE.
REQ-020 After ClearReq is sampled at edge t, the clear writes SHALL occur at edges t+1 .. t+N; ClearDone SHALL be 1 only in the cycle after edge t+N (N=8 at default D).
REQ-021 In CLEAR, WriteReg SHALL be ignored and ClearReq SHALL be ignored; a clear is never restarted by ClearReq.
REQ-022 In IDLE, WriteReg=1 at an edge SHALL set register[WReg] <= WriteValue and set Written[WReg].
REQ-023 When R0_ZERO=1, writes to address 0 SHALL be dropped, Written[0] SHALL stay 0, and reads of address 0 SHALL return 0.
REQ-024 ReadData port i SHALL return register[ReadAddr_i] combinationally with zero latency.
REQ-025 When BYPASS=1, state is IDLE, WriteReg=1 and ReadAddr_i == WReg, port i SHALL return WriteValue in that cycle, subject to REQ-023.
REQ-026 While Busy=1, every ReadData port SHALL return 0.
REQ-027 Duplicate addresses across read ports SHALL each return the same value with no arbitration.

Reset
REQ-028 When Reset=1 at an edge: state <= CLEAR, index <= 0, ClearDone <= 0, Written <= 0, and no register write occurs.
REQ-029 A clear SHALL begin at the first edge with Reset=0, so Busy stays 1 for N edges after Reset deasserts.
REQ-030 Reset asserted mid-clear SHALL restart the clear from index 0.
REQ-031 Reset has priority over ClearReq and WriteReg.

Structure
REQ-032 Package reg_bank_pkg SHALL hold the state enum typedef (IDLE, CLEAR) and the default values of W and D.
REQ-033 The state machine and index counter SHALL live in sub-module reg_bank_clr_fsm (outputs: Busy, ClearDone, clear index, clear write strobe); storage, read muxing and bypass SHALL stay in reg_bank.

Verification
REQ-034 Reset: hold Reset for 2 cycles, then release -> Busy=1 for 8 cycles, ClearDone pulses once, then all 8 registers read 0x00 and Written=8'h00.
REQ-035 Write/read: write 0xA5 to r3, then read r3 on ports 0 and 1 next cycle -> both return 0xA5 and Written[3]=1.
REQ-036 Bypass: with BYPASS=1, write 0x3C to r5 while ReadAddr0=5 in the same cycle -> port 0 returns 0x3C that cycle; with BYPASS=0 it returns the old value.
REQ-037 Clear collision: in IDLE, assert ClearReq and WriteReg (r2<-0x77) together; during Busy, write r4<-0x11 and pulse ClearReq again -> r2=0, r4=0, exactly one ClearDone pulse 8 cycles later.
REQ-038 Mid-clear reset: assert Reset at clear index 4 -> clear restarts at index 0 and ClearDone appears 8 edges after Reset deasserts.
REQ-039 R0_ZERO=1: write 0xFF to r0 -> reads of r0 (including the bypass path) return 0x00 and Written[0]=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register bank and its clear sequencer.
package reg_bank_pkg;

  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned D_DEFAULT = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// Clear sequencer: walks an index across every register, one per clock,
// after reset or on request, and pulses ClearDone when the walk finishes.
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter int unsigned D = D_DEFAULT
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         ClearReq,
  output logic         Busy,
  output logic         ClearDone,
  output logic [D-1:0] ClrIdx,
  output logic         ClrWe
);

  state_t state, state_n;
  logic   last;

  assign last = (ClrIdx == '1);

  always_ff @(posedge CLK) begin
    if (Reset) state <= CLEAR;
    else       state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ClrIdx    <= '0;
      ClearDone <= 1'b0;
    end else begin
      ClearDone <= 1'b0;
      if (state == CLEAR) begin
        ClrIdx <= ClrIdx + D'(1);
        if (last) ClearDone <= 1'b1;
      end else begin
        ClrIdx <= '0;
      end
    end
  end

  always_comb begin
    state_n = state;
    Busy    = 1'b0;
    ClrWe   = 1'b0;
    case (state)
      IDLE: begin
        if (ClearReq) state_n = CLEAR;
      end
      CLEAR: begin
        Busy  = 1'b1;
        // Reset wins over the clear write on the same edge.
        ClrWe = ~Reset;
        if (last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/reg_bank.sv
// Multi-port register bank with optional write-to-read forwarding,
// optional hardwired-zero register 0 and a sequential clear.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned D       = D_DEFAULT,
  parameter int unsigned NR      = 2,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            WriteReg,
  input  logic [D-1:0]    WReg,
  input  logic [W-1:0]    WriteValue,
  input  logic            ClearReq,
  input  logic [NR*D-1:0] ReadAddr,
  output logic [NR*W-1:0] ReadData,
  output logic            Busy,
  output logic            ClearDone,
  output logic [2**D-1:0] Written
);

  localparam int unsigned N = 2**D;

  logic [W-1:0] regs [N];
  logic [D-1:0] clr_idx;
  logic         clr_we;
  logic         user_we;
  logic         r0_drop;
  logic [D-1:0] ra;
  logic [W-1:0] rv;

  reg_bank_clr_fsm #(
    .D(D)
  ) u_clr_fsm (
    .CLK      (CLK),
    .Reset    (Reset),
    .ClearReq (ClearReq),
    .Busy     (Busy),
    .ClearDone(ClearDone),
    .ClrIdx   (clr_idx),
    .ClrWe    (clr_we)
  );

  assign r0_drop = (R0_ZERO != 0) && (WReg == '0);
  // The edge that accepts a clear request performs no user write.
  assign user_we = WriteReg && !Busy && !ClearReq && !Reset && !r0_drop;

  always_ff @(posedge CLK) begin
    if (clr_we)       regs[clr_idx] <= '0;
    else if (user_we) regs[WReg]    <= WriteValue;
  end

  always_ff @(posedge CLK) begin
    if (Reset)        Written          <= '0;
    else if (clr_we)  Written[clr_idx] <= 1'b0;
    else if (user_we) Written[WReg]    <= 1'b1;
  end

  always_comb begin
    ReadData = '0;
    ra       = '0;
    rv       = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      ra = ReadAddr[i*D +: D];
      if (Busy || ((R0_ZERO != 0) && (ra == '0)))
        rv = '0;
      else if ((BYPASS != 0) && WriteReg && (ra == WReg))
        rv = WriteValue;
      else
        rv = regs[ra];
      ReadData[i*W +: W] = rv;
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: default, no-bypass and zero-r0 instances share stimulus.
module tb_reg_bank;

  logic       CLK = 1'b0;
  logic       Reset, WriteReg, ClearReq;
  logic [2:0] WReg;
  logic [7:0] WriteValue;
  logic [5:0] ReadAddr;

  logic [15:0] rd_m, rd_n, rd_z;
  logic        busy_m, busy_n, busy_z, done_m, done_n, done_z;
  logic [7:0]  wr_m, wr_n, wr_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(1), .R0_ZERO(0)) u_dut (
    .CLK(CLK), .Reset(Reset), .WriteReg(WriteReg), .WReg(WReg),
    .WriteValue(WriteValue), .ClearReq(ClearReq), .ReadAddr(ReadAddr),
    .ReadData(rd_m), .Busy(busy_m), .ClearDone(done_m), .Written(wr_m));

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(0), .R0_ZERO(0)) u_nb (
    .CLK(CLK), .Reset(Reset), .WriteReg(WriteReg), .WReg(WReg),
    .WriteValue(WriteValue), .ClearReq(ClearReq), .ReadAddr(ReadAddr),
    .ReadData(rd_n), .Busy(busy_n), .ClearDone(done_n), .Written(wr_n));

  reg_bank #(.W(8), .D(3), .NR(2), .BYPASS(1), .R0_ZERO(1)) u_r0 (
    .CLK(CLK), .Reset(Reset), .WriteReg(WriteReg), .WReg(WReg),
    .WriteValue(WriteValue), .ClearReq(ClearReq), .ReadAddr(ReadAddr),
    .ReadData(rd_z), .Busy(busy_z), .ClearDone(done_z), .Written(wr_z));

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wv;
    logic [2:0] ra0, ra1;
    logic [7:0] e0, e1, n0, z0, wm, wz;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expects CLEAR to be active now: 8 busy cycles, then one ClearDone pulse.
  task automatic expect_clear(input string tag);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk({tag, " busy"}, busy_m, 1);
      chk({tag, " done early"}, done_m, 0);
      chk({tag, " read while busy"}, rd_m, 0);
      step();
    end
    #1;
    chk({tag, " busy end"}, busy_m, 0);
    chk({tag, " done pulse"}, done_m, 1);
    chk({tag, " written"}, wr_m, 0);
    chk({tag, " written r0z"}, wr_z, 0);
    step();
    #1;
    chk({tag, " done low"}, done_m, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          we    wa    wv     ra0   ra1   e0     e1     n0     z0     wm     wz
    tbl[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd0, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h08, 8'h08};
    tbl[2] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd3, 8'h3C, 8'hA5, 8'h00, 8'h3C, 8'h08, 8'h08};
    tbl[3] = '{1'b1, 3'd5, 8'hC3, 3'd5, 3'd5, 8'hC3, 8'hC3, 8'h3C, 8'hC3, 8'h28, 8'h28};
    tbl[4] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd5, 8'hFF, 8'hC3, 8'h00, 8'h00, 8'h28, 8'h28};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h29, 8'h28};
    tbl[6] = '{1'b1, 3'd7, 8'h01, 3'd6, 3'd7, 8'h00, 8'h01, 8'h00, 8'h00, 8'h29, 8'h28};
    tbl[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd2, 8'h01, 8'h00, 8'h01, 8'h01, 8'hA9, 8'hA8};

    Reset = 1'b1; WriteReg = 1'b0; ClearReq = 1'b0;
    WReg = '0; WriteValue = '0; ReadAddr = '0;

    // Reset for two edges, then the post-reset clear.
    step();
    step();
    chk("reset busy", busy_m, 1);
    chk("reset done", done_m, 0);
    chk("reset written", wr_m, 0);
    Reset = 1'b0;
    expect_clear("post-reset");
    for (int a = 0; a < 4; a++) begin
      ReadAddr = 6'(2 * a) | (6'(2 * a + 1) << 3);
      #1;
      chk("post-reset zero", rd_m, 0);
      step();
    end

    for (int v = 0; v < 8; v++) begin
      WriteReg = tbl[v].we;
      WReg = tbl[v].wa;
      WriteValue = tbl[v].wv;
      ReadAddr = {tbl[v].ra1, tbl[v].ra0};
      #1;
      chk($sformatf("vec%0d port0", v), rd_m[7:0], tbl[v].e0);
      chk($sformatf("vec%0d port1", v), rd_m[15:8], tbl[v].e1);
      chk($sformatf("vec%0d nobypass port0", v), rd_n[7:0], tbl[v].n0);
      chk($sformatf("vec%0d r0zero port0", v), rd_z[7:0], tbl[v].z0);
      chk($sformatf("vec%0d written", v), wr_m, tbl[v].wm);
      chk($sformatf("vec%0d r0zero written", v), wr_z, tbl[v].wz);
      step();
    end

    // Clear request coinciding with a write, then writes and a re-request while busy.
    WriteReg = 1'b1; WReg = 3'd2; WriteValue = 8'h77; ClearReq = 1'b1;
    ReadAddr = {3'd4, 3'd2};
    #1;
    chk("collision idle", busy_m, 0);
    step();
    WReg = 3'd4; WriteValue = 8'h11;
    for (int k = 0; k < 8; k++) begin
      ClearReq = (k == 3);
      #1;
      chk("collision busy", busy_m, 1);
      chk("collision done early", done_m, 0);
      chk("collision read while busy", rd_m, 0);
      step();
    end
    WriteReg = 1'b0; ClearReq = 1'b0;
    #1;
    chk("collision done", done_m, 1);
    chk("collision busy end", busy_m, 0);
    chk("collision r2 r4", rd_m, 16'h0000);
    chk("collision written", wr_m, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("collision single pulse", done_m, 0);
      step();
    end
    ReadAddr = {3'd7, 3'd3};
    #1;
    chk("collision r3 r7", rd_m, 16'h0000);
    step();

    // Reset at clear index 4 restarts the walk from index 0.
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    for (int k = 0; k < 4; k++) step();
    Reset = 1'b1;
    #1;
    chk("midclear busy", busy_m, 1);
    step();
    Reset = 1'b0;
    expect_clear("mid-clear reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
